// File: rtl/sm4_ctrl_pkg.sv
// sm4_ctrl_pkg: shared types and constants for the SM4 core controller.
//   state_t     : controller FSM states
//   ADDR_*      : host register map base addresses
//   CTRL_*      : bit positions inside the control register
//   get_word / put_word : 32-bit word access into a 128-bit block,
//                         word 0 being bits [127:96]
package sm4_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        KWAIT,
        BLK,
        BWAIT
    } state_t;

    localparam logic [3:0] ADDR_KEY0  = 4'd0;
    localparam logic [3:0] ADDR_DATA0 = 4'd4;
    localparam logic [3:0] ADDR_IV0   = 4'd8;
    localparam logic [3:0] ADDR_CTRL  = 4'd12;

    localparam int unsigned CTRL_START_KEY = 0;
    localparam int unsigned CTRL_START_BLK = 1;
    localparam int unsigned CTRL_DEC       = 2;
    localparam int unsigned CTRL_CLR       = 3;

    function automatic logic [31:0] get_word(input logic [127:0] v, input logic [1:0] idx);
        logic [31:0] w;
        w = '0;
        case (idx)
            2'd0: w = v[127:96];
            2'd1: w = v[95:64];
            2'd2: w = v[63:32];
            2'd3: w = v[31:0];
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] idx,
                                              input logic [31:0] w);
        logic [127:0] r;
        r = v;
        case (idx)
            2'd0: r[127:96] = w;
            2'd1: r[95:64]  = w;
            2'd2: r[63:32]  = w;
            2'd3: r[31:0]   = w;
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sm4_ctrl_regs.sv
// sm4_ctrl_regs: key/data/IV/result register file and host read mux.
// Optional macro SM4_CTRL_CBC_EN adds the IV register and CBC chaining;
// without it the block runs ECB and IV addresses are ignored / read 0.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   wr_accept          : host write strobe already qualified by !busy
//   wr_addr, wr_data   : host write address / data
//   rd_addr, rd_data   : host read address / combinational read data
//   status             : {key_ok, err, done, busy} for the status word
//   capture            : core result valid while waiting for a block
//   dec                : (CBC only) current operation is decrypt
//   core_result        : result word from the core
//   user_key           : registered key towards the core
//   blk_data           : registered block towards the core
module sm4_ctrl_regs
    import sm4_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_accept,
    input  logic [3:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic [3:0]   rd_addr,
    output logic [31:0]  rd_data,
    input  logic [3:0]   status,
    input  logic         capture,
`ifdef SM4_CTRL_CBC_EN
    input  logic         dec,
`endif
    input  logic [127:0] core_result,
    output logic [127:0] user_key,
    output logic [127:0] blk_data
);

    logic [127:0] key_q;
    logic [127:0] data_q;
    logic [127:0] result_q;
`ifdef SM4_CTRL_CBC_EN
    logic [127:0] iv_q;
    logic [127:0] chain_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
            user_key <= '0;
            blk_data <= '0;
`ifdef SM4_CTRL_CBC_EN
            iv_q     <= '0;
            chain_q  <= '0;
`endif
        end else begin
            if (wr_accept) begin
                case (wr_addr[3:2])
                    ADDR_KEY0[3:2]:  key_q  <= put_word(key_q, wr_addr[1:0], wr_data);
                    ADDR_DATA0[3:2]: data_q <= put_word(data_q, wr_addr[1:0], wr_data);
`ifdef SM4_CTRL_CBC_EN
                    ADDR_IV0[3:2]: begin
                        iv_q    <= put_word(iv_q, wr_addr[1:0], wr_data);
                        chain_q <= put_word(chain_q, wr_addr[1:0], wr_data);
                    end
`endif
                    default: ;
                endcase
            end
            // capture only happens while busy, so it never collides with a write
            if (capture) begin
`ifdef SM4_CTRL_CBC_EN
                if (dec) begin
                    result_q <= core_result ^ chain_q;
                    chain_q  <= data_q;
                end else begin
                    result_q <= core_result;
                    chain_q  <= core_result;
                end
`else
                result_q <= core_result;
`endif
            end
            user_key <= key_q;
`ifdef SM4_CTRL_CBC_EN
            blk_data <= dec ? data_q : (data_q ^ chain_q);
`else
            blk_data <= data_q;
`endif
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr[3:2])
            2'b00: rd_data = get_word(result_q, rd_addr[1:0]);
            2'b01: rd_data = get_word(data_q, rd_addr[1:0]);
`ifdef SM4_CTRL_CBC_EN
            2'b10: rd_data = get_word(iv_q, rd_addr[1:0]);
`endif
            2'b11: if (rd_addr == ADDR_CTRL) rd_data = {28'b0, status};
            default: rd_data = '0;
        endcase
    end

endmodule

// File: rtl/sm4_ctrl.sv
// sm4_ctrl: host-facing controller sequencing an SM4 core through key
// expansion and single-block encrypt/decrypt, with a response watchdog.
// Optional macro SM4_CTRL_CBC_EN enables CBC chaining (see sm4_ctrl_regs).
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data        : host register write
//   rd_addr/rd_data              : host combinational register read
//   busy, done, err              : operation in progress, sticky flags
//   sm4_enable_out .. blk_data_out : registered core controls and data
//   key_exp_ready_in, core_valid_in, core_result_in : core responses
module sm4_ctrl
    import sm4_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [3:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic [3:0]   rd_addr,
    output logic [31:0]  rd_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         sm4_enable_out,
    output logic         enable_key_exp_out,
    output logic         user_key_valid_out,
    output logic [127:0] user_key_out,
    output logic         encdec_sel_out,
    output logic         encdec_enable_out,
    output logic         blk_valid_out,
    output logic [127:0] blk_data_out,
    input  logic         key_exp_ready_in,
    input  logic         core_valid_in,
    input  logic [127:0] core_result_in
);

    localparam int unsigned WW = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    state_t        state_q, state_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          key_ok_q, key_ok_d;
    logic          done_d, err_d, sel_d;
    logic          ctrl_wr, key_wr, capture;

    assign busy    = (state_q != IDLE);
    assign ctrl_wr = wr_en && (wr_addr == ADDR_CTRL);
    assign key_wr  = wr_en && (wr_addr[3:2] == ADDR_KEY0[3:2]) && !busy;

    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        key_ok_d = key_ok_q;
        done_d   = done;
        err_d    = err;
        sel_d    = encdec_sel_out;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_wr) key_ok_d = 1'b0;
                if (ctrl_wr) begin
                    if (wr_data[CTRL_CLR]) begin
                        done_d = 1'b0;
                        err_d  = 1'b0;
                    end
                    if (wr_data[CTRL_START_KEY]) begin
                        sel_d    = wr_data[CTRL_DEC];
                        key_ok_d = 1'b0;
                        state_d  = KEY;
                    end else if (wr_data[CTRL_START_BLK]) begin
                        if (key_ok_q) begin
                            done_d  = 1'b0;
                            state_d = BLK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            KEY: begin
                wdog_d  = '0;
                state_d = KWAIT;
            end
            KWAIT: begin
                if (key_exp_ready_in) begin
                    key_ok_d = 1'b1;
                    state_d  = IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    err_d    = 1'b1;
                    key_ok_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            BLK: begin
                wdog_d  = '0;
                state_d = BWAIT;
            end
            BWAIT: begin
                // a response arriving on the timeout cycle still counts
                if (core_valid_in) begin
                    capture = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (ctrl_wr && busy) err_d = 1'b1;
    end

    // Core strobes are registered from the next state so they line up
    // with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= IDLE;
            wdog_q             <= '0;
            key_ok_q           <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            encdec_sel_out     <= 1'b0;
            sm4_enable_out     <= 1'b0;
            enable_key_exp_out <= 1'b0;
            user_key_valid_out <= 1'b0;
            encdec_enable_out  <= 1'b0;
            blk_valid_out      <= 1'b0;
        end else begin
            state_q            <= state_d;
            wdog_q             <= wdog_d;
            key_ok_q           <= key_ok_d;
            done               <= done_d;
            err                <= err_d;
            encdec_sel_out     <= sel_d;
            sm4_enable_out     <= key_ok_d | (state_d != IDLE);
            enable_key_exp_out <= (state_d == KEY) || (state_d == KWAIT);
            user_key_valid_out <= (state_d == KEY);
            encdec_enable_out  <= (state_d == BLK) || (state_d == BWAIT);
            blk_valid_out      <= (state_d == BLK);
        end
    end

    sm4_ctrl_regs u_regs (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_accept   (wr_en && !busy),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .status      ({key_ok_q, err, done, busy}),
        .capture     (capture),
`ifdef SM4_CTRL_CBC_EN
        .dec         (encdec_sel_out),
`endif
        .core_result (core_result_in),
        .user_key    (user_key_out),
        .blk_data    (blk_data_out)
    );

endmodule

// File: tb/tb_sm4_ctrl.sv
module tb_sm4_ctrl;

    localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] CT2 = 128'hfeedface0badf00d1122334455667788;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [3:0]   wr_addr = '0;
    logic [31:0]  wr_data = '0;
    logic [3:0]   rd_addr = '0;
    logic [31:0]  rd_data;
    logic         busy, done, err;
    logic         sm4_enable_out, enable_key_exp_out, user_key_valid_out;
    logic [127:0] user_key_out;
    logic         encdec_sel_out, encdec_enable_out, blk_valid_out;
    logic [127:0] blk_data_out;
    logic         key_exp_ready_in = 1'b0;
    logic         core_valid_in = 1'b0;
    logic [127:0] core_result_in = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sm4_ctrl #(.WDOG_CYCLES(255)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .sm4_enable_out(sm4_enable_out), .enable_key_exp_out(enable_key_exp_out),
        .user_key_valid_out(user_key_valid_out), .user_key_out(user_key_out),
        .encdec_sel_out(encdec_sel_out), .encdec_enable_out(encdec_enable_out),
        .blk_valid_out(blk_valid_out), .blk_data_out(blk_data_out),
        .key_exp_ready_in(key_exp_ready_in), .core_valid_in(core_valid_in),
        .core_result_in(core_result_in)
    );

    function automatic logic [31:0] wd(input logic [127:0] v, input int i);
        return v[127-32*i -: 32];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic load_block(input logic [3:0] base, input logic [127:0] v);
        for (int i = 0; i < 4; i++) wr(base + 4'(i), wd(v, i));
    endtask

    // returns {sm4_en, kexp_en, key_valid, sel, encdec_en, blk_valid}
    function automatic logic [5:0] flags();
        return {sm4_enable_out, enable_key_exp_out, user_key_valid_out,
                encdec_sel_out, encdec_enable_out, blk_valid_out};
    endfunction

    initial begin
        // ---- reset state
        tick(); tick();
        #2 reset_n = 1'b1;
        tick();
        chk("rst_flags", flags(), 6'b000000);
        chk("rst_hostflags", {busy, done, err}, 3'b000);
        chk("rst_key_out", user_key_out, '0);
        chk("rst_blk_out", blk_data_out, '0);
        rd_chk("rst_status", 4'd12, 32'h0);
        rd_chk("rst_result", 4'd0, 32'h0);

        // ---- start_blk without a key
        wr(4'd12, 32'h2);
        chk("nokey_err", err, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("nokey_blkvalid", blk_valid_out, 1'b0);
            chk("nokey_busy", busy, 1'b0);
            tick();
        end
        rd_chk("nokey_status", 4'd12, 32'h4);
        wr(4'd12, 32'h8);
        rd_chk("clr_status", 4'd12, 32'h0);

        // ---- key expansion, encrypt mode
        load_block(4'd0, KEY);
        load_block(4'd4, PT);
        rd_chk("data_w0", 4'd4, 32'h01234567);
        rd_chk("data_w3", 4'd7, 32'h76543210);
        wr(4'd12, 32'h1);
        chk("key_flags", flags(), 6'b111000);
        chk("key_busy", busy, 1'b1);
        chk("key_out", user_key_out, KEY);
        tick();
        chk("kwait_flags", flags(), 6'b110000);
        wr(4'd4, 32'hdeadbeef);
        rd_chk("busy_data_ignored", 4'd4, 32'h01234567);
        chk("busy_data_noerr", err, 1'b0);
        key_exp_ready_in = 1'b1;
        tick();
        key_exp_ready_in = 1'b0;
        chk("keyok_flags", flags(), 6'b100000);
        rd_chk("keyok_status", 4'd12, 32'h8);

        // ---- core_valid outside BWAIT is ignored
        core_result_in = '1; core_valid_in = 1'b1;
        tick();
        core_valid_in = 1'b0;
        rd_chk("stray_valid_result", 4'd0, 32'h0);
        chk("stray_valid_done", done, 1'b0);

        // ---- encrypt block
        wr(4'd12, 32'h2);
        chk("blk_flags", flags(), 6'b100011);
        chk("blk_data_enc", blk_data_out, PT);
        tick();
        chk("bwait_flags", flags(), 6'b100010);
        wr(4'd12, 32'h8);
        rd_chk("busy_ctrl_err", 4'd12, 32'hD);
        core_result_in = CT; core_valid_in = 1'b1;
        tick();
        core_valid_in = 1'b0;
        chk("enc_done_flags", {busy, done, err}, 3'b011);
        chk("enc_encdec_drop", encdec_enable_out, 1'b0);
        for (int i = 0; i < 4; i++) rd_chk("enc_result", 4'(i), wd(CT, i));
        rd_chk("enc_status", 4'd12, 32'hE);
        wr(4'd12, 32'h8);
        rd_chk("clr2_status", 4'd12, 32'h8);

        // ---- IV window and unmapped address
        wr(4'd8, 32'h12345678);
`ifdef SM4_CTRL_CBC_EN
        rd_chk("iv_read", 4'd8, 32'h12345678);
`else
        rd_chk("iv_read", 4'd8, 32'h0);
`endif
        for (int i = 0; i < 4; i++) wr(4'd8 + 4'(i), 32'h0);
        rd_chk("unmapped_read", 4'd13, 32'h0);

        // ---- decrypt
        wr(4'd12, 32'h5);
        chk("dec_sel", encdec_sel_out, 1'b1);
        rd_chk("dec_key_status", 4'd12, 32'h1);
        tick();
        key_exp_ready_in = 1'b1;
        tick();
        key_exp_ready_in = 1'b0;
        load_block(4'd4, CT);
        wr(4'd12, 32'h2);
        chk("blk_data_dec", blk_data_out, CT);
        tick();
        core_result_in = PT; core_valid_in = 1'b1;
        tick();
        core_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) rd_chk("dec_result", 4'(i), wd(PT, i));
        rd_chk("dec_status", 4'd12, 32'hA);

        // ---- watchdog in BWAIT
        wr(4'd12, 32'h2);
        tick();
        for (int i = 0; i < 254; i++) tick();
        chk("wdog_before", {busy, err}, 2'b10);
        tick();
        chk("wdog_expire", {busy, err}, 2'b01);
        chk("wdog_flags", flags(), 6'b100100);
        rd_chk("wdog_status", 4'd12, 32'hC);
        wr(4'd12, 32'h8);

        // ---- key write clears key_ok
        wr(4'd0, wd(KEY, 0));
        rd_chk("keywr_status", 4'd12, 32'h0);
        chk("keywr_sm4en", sm4_enable_out, 1'b0);

        // ---- start_key + start_blk together runs key only
        wr(4'd12, 32'h3);
        chk("both_flags", flags(), 6'b111000);
        rd_chk("both_status", 4'd12, 32'h1);
        tick();

        // ---- reset during KWAIT
        reset_n = 1'b0;
        #1;
        chk("arst_flags", flags(), 6'b000000);
        chk("arst_hostflags", {busy, done, err}, 3'b000);
        chk("arst_key_out", user_key_out, '0);
        chk("arst_blk_out", blk_data_out, '0);
        #1 reset_n = 1'b1;
        tick();
        rd_chk("arst_status", 4'd12, 32'h0);
        rd_chk("arst_data", 4'd4, 32'h0);

        // ---- two identical plaintext blocks
        load_block(4'd0, KEY);
        wr(4'd12, 32'h1);
        tick();
        key_exp_ready_in = 1'b1;
        tick();
        key_exp_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) wr(4'd8 + 4'(i), 32'h0);
        load_block(4'd4, PT);
        wr(4'd12, 32'h2);
        chk("blk1_data", blk_data_out, PT);
        tick();
        core_result_in = CT; core_valid_in = 1'b1;
        tick();
        core_valid_in = 1'b0;
        rd_chk("blk1_result", 4'd0, wd(CT, 0));
        wr(4'd12, 32'h2);
`ifdef SM4_CTRL_CBC_EN
        chk("blk2_data", blk_data_out, PT ^ CT);
`else
        chk("blk2_data", blk_data_out, PT);
`endif
        tick();
        core_result_in = CT2; core_valid_in = 1'b1;
        tick();
        core_valid_in = 1'b0;
        rd_chk("blk2_result", 4'd3, wd(CT2, 3));
        chk("blk2_done", done, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
